uart_alu_interface: RTL

Command sequencer between the UART receiver and the UART transmitter. It collects three received bytes in order: operand A, operand B, then opcode. It presents them to the external combinational ALU, latches the ALU result, and hands it to the transmitter with a one-cycle start pulse. It then waits for the transmitter to report completion before accepting the next command.

---
 rtl/uart_alu_interface_if.sv | 29 ++
 rtl/uart_alu_interface.sv | 116 +++++++++++
 2 files changed

// File: rtl/uart_alu_interface_if.sv
// Bundles the receiver, ALU and transmitter connections of the command sequencer.
interface uart_alu_interface_if #(
  parameter int BITS_DATA = 8,
  parameter int BITS_OP   = 6
);
  logic                 i_rx_done_tick;
  logic [BITS_DATA-1:0] i_rx_data;
  logic [BITS_DATA-1:0] i_alu_result;
  logic                 i_tx_done_tick;
  logic [BITS_DATA-1:0] o_alu_a;
  logic [BITS_DATA-1:0] o_alu_b;
  logic [BITS_OP-1:0]   o_alu_op;
  logic [BITS_DATA-1:0] o_tx_data;
  logic                 o_tx_start;
  logic                 o_busy;
  logic                 o_drop;

  // Environment side: drives receiver/ALU/transmitter inputs, observes the sequencer.
  modport master (
    output i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_drop
  );

  // Sequencer side.
  modport slave (
    input  i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_drop
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Command sequencer: collects A, B and opcode bytes from the UART receiver,
// latches the external ALU result and hands it to the UART transmitter.
module uart_alu_interface #(
  parameter int BITS_DATA = 8,
  parameter int BITS_OP   = 6
) (
  input logic                 i_clk,
  input logic                 i_reset,
  uart_alu_interface_if.slave bus
);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    LATCH,
    SEND,
    WAIT_TX
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 load_a;
  logic                 load_b;
  logic                 load_op;
  logic                 load_res;
  logic                 drop_next;
  logic                 drop;
  logic                 tx_start;
  logic                 busy;
  logic [BITS_DATA-1:0] alu_a;
  logic [BITS_DATA-1:0] alu_b;
  logic [BITS_OP-1:0]   alu_op;
  logic [BITS_DATA-1:0] tx_data;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= GET_A;
    else         state <= state_next;
  end

  // Next-state, register load enables and Moore outputs.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_res   = 1'b0;
    drop_next  = 1'b0;
    tx_start   = 1'b0;
    busy       = 1'b1;
    unique case (state)
      GET_A: begin
        busy = 1'b0;
        if (bus.i_rx_done_tick) begin
          load_a     = 1'b1;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (bus.i_rx_done_tick) begin
          load_b     = 1'b1;
          state_next = GET_OP;
        end
      end
      GET_OP: begin
        if (bus.i_rx_done_tick) begin
          load_op    = 1'b1;
          state_next = LATCH;
        end
      end
      LATCH: begin
        load_res   = 1'b1;
        drop_next  = bus.i_rx_done_tick;
        state_next = SEND;
      end
      SEND: begin
        tx_start   = 1'b1;
        drop_next  = bus.i_rx_done_tick;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        // A byte arriving together with tx_done is still dropped, not taken as A.
        drop_next = bus.i_rx_done_tick;
        if (bus.i_tx_done_tick) state_next = GET_A;
      end
      default: state_next = GET_A;
    endcase
  end

  // Operand, opcode, result and drop registers; held until overwritten or reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
      drop    <= 1'b0;
    end else begin
      if (load_a)   alu_a   <= bus.i_rx_data;
      if (load_b)   alu_b   <= bus.i_rx_data;
      if (load_op)  alu_op  <= bus.i_rx_data[BITS_OP-1:0];
      if (load_res) tx_data <= bus.i_alu_result;
      drop <= drop_next;
    end
  end

  assign bus.o_alu_a    = alu_a;
  assign bus.o_alu_b    = alu_b;
  assign bus.o_alu_op   = alu_op;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_start = tx_start;
  assign bus.o_busy     = busy;
  assign bus.o_drop     = drop;

endmodule
